// File: rtl/ia_comp_pkg.sv
// Shared types, widths and helpers for the IA compressor.
// Holds the FSM state enum, default sizing and the iteration-count function.
package ia_comp_pkg;

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2
    } state_t;

    localparam int IA_CHANNELS = 32;
    localparam int IA_GROUP    = 32;
    localparam int IA_LEN_W    = $clog2(IA_CHANNELS) + 1;
    localparam int IA_CH_W     = $clog2(IA_CHANNELS);

    // Number of extra AIM passes: ceil(len/group)-1, zero for an empty vector.
    function automatic int ia_iters(input int len, input int group);
        if (len == 0)
            return 0;
        return (len + group - 1) / group - 1;
    endfunction

endpackage

// File: rtl/ia_nz_detect.sv
// Keep/drop decision for one dense IA beat (combinational).
// Ports: i_data (signed value), i_thresh (IA_COMP_THRESH_EN only), o_keep.
module ia_nz_detect #(
    parameter int DATA_W = 16
) (
    input  logic signed [DATA_W-1:0] i_data,
`ifdef IA_COMP_THRESH_EN
    input  logic        [DATA_W-2:0] i_thresh,
`endif
    output logic                     o_keep
);

`ifdef IA_COMP_THRESH_EN
    logic [DATA_W-1:0] neg;
    logic [DATA_W-2:0] mag;

    assign neg = -i_data;

    // |x| with the most-negative code saturated to the largest magnitude.
    always_comb begin
        mag = i_data[DATA_W-2:0];
        if (i_data[DATA_W-1]) begin
            if (i_data[DATA_W-2:0] == '0)
                mag = '1;
            else
                mag = neg[DATA_W-2:0];
        end
    end

    assign o_keep = (mag > i_thresh);
`else
    assign o_keep = |i_data;
`endif

endmodule

// File: rtl/ia_compressor.sv
// Packs a channel-serial dense IA vector into the sparse PE bundle.
// Ports: i_clk/i_rst, dense beat stream (i_valid/o_ready/i_data/i_last/i_h/i_w),
// bundle outputs o_ia_*, PE handshake o_pe_start/i_pe_finish, o_skip.
// Optional macro IA_COMP_THRESH_EN adds i_thresh magnitude thresholding.
module ia_compressor
    import ia_comp_pkg::*;
#(
    parameter int CHANNELS = IA_CHANNELS,
    parameter int DATA_W   = 16,
    parameter int CIDX_W   = 8,
    parameter int GROUP    = IA_GROUP,
    parameter int HW_W     = 7,
    localparam int LEN_W   = $clog2(CHANNELS) + 1,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_valid,
    output logic                             o_ready,
    input  logic signed [DATA_W-1:0]         i_data,
    input  logic                             i_last,
    input  logic        [HW_W-1:0]           i_h,
    input  logic        [HW_W-1:0]           i_w,
`ifdef IA_COMP_THRESH_EN
    input  logic        [DATA_W-2:0]         i_thresh,
`endif
    output logic [CHANNELS-1:0][DATA_W-1:0]  o_ia_data,
    output logic [CHANNELS-1:0][CIDX_W-1:0]  o_ia_c_idx,
    output logic [LEN_W-1:0]                 o_ia_len,
    output logic [LEN_W-1:0]                 o_ia_iters,
    output logic [HW_W-1:0]                  o_ia_h,
    output logic [HW_W-1:0]                  o_ia_w,
    output logic                             o_pe_start,
    input  logic                             i_pe_finish,
    output logic                             o_skip
);

    state_t                          state;
    logic [CH_W-1:0]                 ch;
    logic [LEN_W-1:0]                len_q;
    logic [LEN_W-1:0]                iters_q;
    logic [CHANNELS-1:0][DATA_W-1:0] data_q;
    logic [CHANNELS-1:0][CIDX_W-1:0] cidx_q;
    logic [HW_W-1:0]                 h_q;
    logic [HW_W-1:0]                 w_q;
    logic                            skip_q;

    logic             first;
    logic             keep;
    logic             close;
    logic [LEN_W-1:0] base_len;
    logic [LEN_W-1:0] new_len;
    logic [CH_W-1:0]  slot;

    assign first    = (ch == '0);
    // A new vector restarts packing at slot 0 in the same cycle.
    assign base_len = first ? '0 : len_q;
    assign new_len  = base_len + LEN_W'(keep);
    assign slot     = base_len[CH_W-1:0];
    assign close    = i_last || (ch == CH_W'(CHANNELS - 1));

`ifdef IA_COMP_THRESH_EN
    logic [DATA_W-2:0] thresh_q;
    logic [DATA_W-2:0] thresh;

    // Threshold is taken live on the first beat, then held for the vector.
    assign thresh = first ? i_thresh : thresh_q;

    ia_nz_detect #(.DATA_W(DATA_W)) u_nz (
        .i_data   (i_data),
        .i_thresh (thresh),
        .o_keep   (keep)
    );
`else
    ia_nz_detect #(.DATA_W(DATA_W)) u_nz (
        .i_data (i_data),
        .o_keep (keep)
    );
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= S_COLLECT;
            ch      <= '0;
            len_q   <= '0;
            iters_q <= '0;
            data_q  <= '0;
            cidx_q  <= '0;
            h_q     <= '0;
            w_q     <= '0;
            skip_q  <= 1'b0;
`ifdef IA_COMP_THRESH_EN
            thresh_q <= '0;
`endif
        end else begin
            skip_q <= 1'b0;
            unique case (state)
                S_COLLECT: begin
                    if (i_valid) begin
                        if (first) begin
                            data_q <= '0;
                            cidx_q <= '0;
                            h_q    <= i_h;
                            w_q    <= i_w;
`ifdef IA_COMP_THRESH_EN
                            thresh_q <= i_thresh;
`endif
                        end
                        if (keep) begin
                            data_q[slot] <= i_data;
                            cidx_q[slot] <= CIDX_W'(ch);
                        end
                        len_q   <= new_len;
                        iters_q <= LEN_W'(ia_iters(32'(new_len), GROUP));
                        if (close) begin
                            ch <= '0;
                            if (new_len != '0)
                                state <= S_ISSUE;
                            else
                                skip_q <= 1'b1;
                        end else begin
                            ch <= ch + CH_W'(1);
                        end
                    end
                end
                // Finish is still high from the previous job here; ignore it.
                S_ISSUE: state <= S_WAIT;
                S_WAIT: begin
                    if (i_pe_finish)
                        state <= S_COLLECT;
                end
                default: state <= S_COLLECT;
            endcase
        end
    end

    assign o_ready    = (state == S_COLLECT);
    assign o_pe_start = (state == S_ISSUE);
    assign o_skip     = skip_q;
    assign o_ia_data  = data_q;
    assign o_ia_c_idx = cidx_q;
    assign o_ia_len   = len_q;
    assign o_ia_iters = iters_q;
    assign o_ia_h     = h_q;
    assign o_ia_w     = w_q;

endmodule

// File: tb/tb_ia_compressor.sv
// Self-checking bench for ia_compressor: directed cases plus random vectors
// checked every cycle against a queue-based behavioural model.
module tb_ia_compressor;

    localparam int CH  = 32;
    localparam int DW  = 16;
    localparam int CW  = 8;
    localparam int HW  = 7;
    localparam int LW  = 6;
    localparam int GRP = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              valid;
    logic              ready;
    logic [DW-1:0]     data;
    logic              last;
    logic [HW-1:0]     h;
    logic [HW-1:0]     w;
`ifdef IA_COMP_THRESH_EN
    logic [DW-2:0]     thresh;
`endif
    logic [CH-1:0][DW-1:0] ia_data;
    logic [CH-1:0][CW-1:0] ia_cidx;
    logic [LW-1:0]     ia_len;
    logic [LW-1:0]     ia_iters;
    logic [HW-1:0]     ia_h;
    logic [HW-1:0]     ia_w;
    logic              pe_start;
    logic              finish;
    logic              skip;

    always #5 clk = ~clk;

    ia_compressor dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_valid     (valid),
        .o_ready     (ready),
        .i_data      (data),
        .i_last      (last),
        .i_h         (h),
        .i_w         (w),
`ifdef IA_COMP_THRESH_EN
        .i_thresh    (thresh),
`endif
        .o_ia_data   (ia_data),
        .o_ia_c_idx  (ia_cidx),
        .o_ia_len    (ia_len),
        .o_ia_iters  (ia_iters),
        .o_ia_h      (ia_h),
        .o_ia_w      (ia_w),
        .o_pe_start  (pe_start),
        .i_pe_finish (finish),
        .o_skip      (skip)
    );

    int pass_cnt = 0;
    int total    = 0;

    task automatic chk(input string nm, input logic [511:0] act,
                       input logic [511:0] exp);
        total++;
        if (act === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    int            m_phase;   // 0 collecting, 1 issuing, 2 waiting on PE
    int            m_beats;
    bit            m_init = 0;
    bit            m_skip;
    bit            m_after_rst;
    logic [DW-1:0] q_d[$];
    logic [CW-1:0] q_i[$];
    logic [HW-1:0] cur_h;
    logic [HW-1:0] cur_w;
    logic [CH-1:0][DW-1:0] e_data;
    logic [CH-1:0][CW-1:0] e_cidx;
    int            e_len;
    logic [HW-1:0] e_h;
    logic [HW-1:0] e_w;
`ifdef IA_COMP_THRESH_EN
    logic [DW-2:0] m_th;
`endif

    function automatic bit m_keep(input logic [DW-1:0] d);
`ifdef IA_COMP_THRESH_EN
        int a;
        a = int'($signed(d));
        if (a < 0) a = -a;
        if (a > 32767) a = 32767;
        return a > int'(m_th);
`else
        return d != 0;
`endif
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_init      = 1;
            m_phase     = 0;
            m_beats     = 0;
            m_skip      = 0;
            m_after_rst = 1;
            q_d.delete();
            q_i.delete();
            e_data = '0;
            e_cidx = '0;
            e_len  = 0;
            e_h    = '0;
            e_w    = '0;
        end else if (m_init) begin
            m_after_rst = 0;
            m_skip      = 0;
            case (m_phase)
                0: if (valid) begin
                    if (m_beats == 0) begin
                        q_d.delete();
                        q_i.delete();
                        cur_h = h;
                        cur_w = w;
`ifdef IA_COMP_THRESH_EN
                        m_th = thresh;
`endif
                    end
                    if (m_keep(data)) begin
                        q_d.push_back(data);
                        q_i.push_back(CW'(m_beats));
                    end
                    m_beats++;
                    if (last || m_beats == CH) begin
                        m_beats = 0;
                        e_data  = '0;
                        e_cidx  = '0;
                        foreach (q_d[k]) begin
                            e_data[k] = q_d[k];
                            e_cidx[k] = q_i[k];
                        end
                        e_len = q_d.size();
                        e_h   = cur_h;
                        e_w   = cur_w;
                        if (e_len > 0) m_phase = 1;
                        else m_skip = 1;
                    end
                end
                1: m_phase = 2;
                default: if (finish) m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("ready", 512'(ready), 512'(m_phase == 0));
            chk("start", 512'(pe_start), 512'(m_phase == 1));
            chk("skip", 512'(skip), 512'(m_skip));
            if (m_phase != 0 || m_skip || m_after_rst) begin
                chk("len", 512'(ia_len), 512'(e_len));
                chk("iters", 512'(ia_iters),
                    512'(e_len == 0 ? 0 : (e_len - 1) / GRP));
                chk("h", 512'(ia_h), 512'(e_h));
                chk("w", 512'(ia_w), 512'(e_w));
                chk("data", 512'(ia_data), 512'(e_data));
                chk("cidx", 512'(ia_cidx), 512'(e_cidx));
            end
        end
    end

    // ---------------- driver ----------------
    logic [DW-1:0] vec[CH];

    task automatic clear_vec();
        for (int i = 0; i < CH; i++) vec[i] = '0;
    endtask

    task automatic send(input int n, input bit with_last, input int gap_max);
        for (int i = 0; i < n; i++) begin
            if (gap_max > 0) begin
                valid = 1'b0;
                repeat ($urandom_range(gap_max, 0)) @(negedge clk);
            end
            valid = 1'b1;
            data  = vec[i];
            last  = with_last && (i == n - 1);
            for (int g = 0; g < 50 && !ready; g++) @(negedge clk);
            chk("beat_ready", 512'(ready), 512'(1));
            @(negedge clk);
        end
        valid = 1'b0;
        last  = 1'b0;
        data  = DW'($urandom);
    endtask

    task automatic wait_job(output int res);
        res = 0;
        for (int k = 0; k < 4 && res == 0; k++) begin
            if (pe_start) res = 1;
            else if (skip) res = 2;
            else @(negedge clk);
        end
        if (res == 0) chk("job_timeout", 512'(pe_start | skip), 512'(1));
    endtask

    task automatic finish_job(input bit fin_in_issue, input int dly);
        finish = fin_in_issue;
        @(negedge clk);
        finish = 1'b0;
        repeat (dly) @(negedge clk);
        finish = 1'b1;
        @(negedge clk);
        finish = 1'b0;
    endtask

    initial begin
        int res;
        rst    = 1'b1;
        valid  = 1'b0;
        last   = 1'b0;
        data   = '0;
        h      = '0;
        w      = '0;
        finish = 1'b0;
`ifdef IA_COMP_THRESH_EN
        thresh = '0;
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", 512'(ready), 512'(1));
        chk("rst_len", 512'(ia_len), 512'(0));

        // Basic pack
        clear_vec();
        vec[3] = 16'd5; vec[17] = 16'hFFFE; vec[31] = 16'd9;
        h = 7'd12; w = 7'd34;
        send(32, 1, 0);
        chk("basic_start", 512'(pe_start), 512'(1));
        chk("basic_len", 512'(ia_len), 512'(3));
        chk("basic_d0", 512'(ia_data[0]), 512'(16'd5));
        chk("basic_d1", 512'(ia_data[1]), 512'(16'hFFFE));
        chk("basic_d2", 512'(ia_data[2]), 512'(16'd9));
        chk("basic_c0", 512'(ia_cidx[0]), 512'(3));
        chk("basic_c1", 512'(ia_cidx[1]), 512'(17));
        chk("basic_c2", 512'(ia_cidx[2]), 512'(31));
        chk("basic_iters", 512'(ia_iters), 512'(0));
        chk("basic_h", 512'(ia_h), 512'(12));
        finish_job(1'b0, 2);

        // Dense vector, forced close at the last channel
        for (int i = 0; i < CH; i++) vec[i] = DW'(i + 100);
        send(32, 0, 0);
        chk("dense_start", 512'(pe_start), 512'(1));
        chk("dense_len", 512'(ia_len), 512'(32));
        chk("dense_iters", 512'(ia_iters), 512'(0));
        finish = 1'b1;
        @(negedge clk);
        chk("dense_ignore_fin", 512'(ready), 512'(0));
        finish = 1'b0;
        repeat (3) @(negedge clk);
        chk("dense_hold", 512'(ready), 512'(0));
        finish = 1'b1;
        @(negedge clk);
        finish = 1'b0;
        chk("dense_reopen", 512'(ready), 512'(1));

        // Early last after a full vector
        clear_vec();
        vec[2] = 16'd4; vec[7] = 16'd1;
        send(8, 1, 0);
        chk("early_len", 512'(ia_len), 512'(2));
        chk("early_c0", 512'(ia_cidx[0]), 512'(2));
        chk("early_c1", 512'(ia_cidx[1]), 512'(7));
        chk("early_hi", 512'(ia_data[31:2]), 512'(0));
        finish_job(1'b0, 1);

        // All-zero vector, then back-to-back next vector
        clear_vec();
        send(32, 1, 0);
        chk("zero_skip", 512'(skip), 512'(1));
        chk("zero_nostart", 512'(pe_start), 512'(0));
        chk("zero_ready", 512'(ready), 512'(1));
        vec[0] = 16'd3;
        send(2, 1, 0);
        chk("after_skip_len", 512'(ia_len), 512'(1));
        finish_job(1'b0, 0);

        // Reset mid-collection
        for (int i = 0; i < CH; i++) vec[i] = DW'(i + 1);
        send(10, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_ready", 512'(ready), 512'(1));
        chk("mrst_data", 512'(ia_data), 512'(0));
        clear_vec();
        vec[0] = 16'd7;
        send(5, 1, 0);
        chk("mrst_c0", 512'(ia_cidx[0]), 512'(0));
        chk("mrst_len", 512'(ia_len), 512'(1));
        // Reset while waiting on the PE
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("wrst_ready", 512'(ready), 512'(1));
        chk("wrst_len", 512'(ia_len), 512'(0));

`ifdef IA_COMP_THRESH_EN
        clear_vec();
        thresh = 15'd3;
        vec[0] = 16'd3; vec[1] = 16'hFFFC; vec[2] = 16'hFFFD;
        vec[3] = 16'd4; vec[4] = 16'h8000;
        send(5, 1, 0);
        chk("th_len", 512'(ia_len), 512'(3));
        chk("th_d0", 512'(ia_data[0]), 512'(16'hFFFC));
        chk("th_d1", 512'(ia_data[1]), 512'(16'd4));
        chk("th_d2", 512'(ia_data[2]), 512'(16'h8000));
        chk("th_c", 512'({ia_cidx[2], ia_cidx[1], ia_cidx[0]}),
            512'(24'h040301));
        finish_job(1'b0, 0);
`endif

        // Random vectors
        for (int v = 0; v < 60; v++) begin
            int n;
            int p;
            bit wl;
            n  = $urandom_range(32, 1);
            p  = $urandom_range(100, 0);
            wl = (n < 32) ? 1'b1 : 1'($urandom_range(1, 0));
            for (int i = 0; i < CH; i++) begin
                if ($urandom_range(99, 0) < p) begin
                    vec[i] = ($urandom_range(1, 0) != 0) ?
                             DW'($urandom) : DW'($urandom_range(9, 0) - 5);
                end else begin
                    vec[i] = '0;
                end
            end
            h = HW'($urandom);
            w = HW'($urandom);
`ifdef IA_COMP_THRESH_EN
            thresh = 15'($urandom_range(6, 0));
`endif
            send(n, wl, $urandom_range(2, 0));
            wait_job(res);
            if (res == 1)
                finish_job(1'($urandom_range(1, 0)), $urandom_range(5, 0));
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
